abus_arbiter: RTL and testbench

Central arbiter for the shared abus. It collects `abus_mreq` from up to eight `abus_master` instances and grants the bus to exactly one at a time, in round-robin order. A grant is held until the owning transfer completes with `abus_mack`, or until a watchdog expires. The block sits between the masters and the shared bus, and publishes the owner ID for slave-side decode and muxing.

---
 rtl/abus_arbiter_pkg.sv | 18 +
 rtl/abus_rr_pick.sv | 31 +++
 rtl/abus_arbiter.sv | 118 +++++++++++
 tb/tb_abus_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/abus_arbiter_pkg.sv
// Shared types and helpers for the abus round-robin arbiter.
// Holds the arbiter state encoding and the watchdog counter sizing rule.
package abus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_ARB_IDLE    = 2'd0,
        S_ARB_GRANT   = 2'd1,
        S_ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam int GID_W = 3;

    // A disabled watchdog (timeout of 0) still gets a 1-bit counter.
    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/abus_rr_pick.sv
// Combinational round-robin picker: finds the first set request
// searching upward from last+1, wrapping modulo NB_MASTERS.
module abus_rr_pick
    import abus_arbiter_pkg::*;
#(
    parameter int NB_MASTERS = 4
) (
    input  logic [NB_MASTERS-1:0] req,
    input  logic [GID_W-1:0]      last,
    output logic [NB_MASTERS-1:0] onehot,
    output logic [GID_W-1:0]      idx,
    output logic                  any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 1; i <= NB_MASTERS; i++) begin
            // Nested loop keeps every select a constant index after unrolling.
            for (int j = 0; j < NB_MASTERS; j++) begin
                if (!any && req[j] && (j == ((int'(last) + i) % NB_MASTERS))) begin
                    any       = 1'b1;
                    onehot[j] = 1'b1;
                    idx       = GID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/abus_arbiter.sv
// Central abus arbiter: round-robin grant to one master at a time, held
// until abus_mack, an early request drop, or watchdog expiry.
module abus_arbiter
    import abus_arbiter_pkg::*;
#(
    parameter int NB_MASTERS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  abus_clk,
    input  logic                  abus_rstb,
    input  logic [NB_MASTERS-1:0] abus_mreq,
    input  logic                  abus_mack,
    output logic [NB_MASTERS-1:0] abus_mgrant,
    output logic [GID_W-1:0]      abus_gid,
    output logic                  abus_gvalid,
    output logic                  abus_timeout
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e            state_q, state_d;
    logic [NB_MASTERS-1:0] mgrant_q, mgrant_d;
    logic [GID_W-1:0]      gid_q, gid_d;
    logic                  gvalid_q, gvalid_d;
    logic                  timeout_q, timeout_d;
    logic [GID_W-1:0]      last_q, last_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic [NB_MASTERS-1:0] pick_onehot;
    logic [GID_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  owner_req;

    abus_rr_pick #(
        .NB_MASTERS (NB_MASTERS)
    ) u_pick (
        .req    (abus_mreq),
        .last   (last_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The grant is one-hot, so masking with it selects the owner's request.
    assign owner_req = |(abus_mreq & mgrant_q);

    always_comb begin
        state_d   = state_q;
        mgrant_d  = mgrant_q;
        gid_d     = gid_q;
        gvalid_d  = gvalid_q;
        timeout_d = 1'b0;
        last_d    = last_q;
        wd_d      = wd_q;
        unique case (state_q)
            S_ARB_IDLE: begin
                wd_d = '0;
                if (pick_any) begin
                    mgrant_d = pick_onehot;
                    gid_d    = pick_idx;
                    gvalid_d = 1'b1;
                    last_d   = pick_idx;
                    state_d  = S_ARB_GRANT;
                end
            end
            S_ARB_GRANT: begin
                wd_d = wd_q + WD_W'(1);
                // Completion and early drop both outrank the watchdog.
                if (!owner_req || abus_mack) begin
                    mgrant_d = '0;
                    gid_d    = '0;
                    gvalid_d = 1'b0;
                    state_d  = S_ARB_RELEASE;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    mgrant_d  = '0;
                    gid_d     = '0;
                    gvalid_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_ARB_RELEASE;
                end
            end
            S_ARB_RELEASE: begin
                wd_d    = '0;
                state_d = S_ARB_IDLE;
            end
            default: begin
                state_d = S_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            state_q   <= S_ARB_IDLE;
            mgrant_q  <= '0;
            gid_q     <= '0;
            gvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= GID_W'(NB_MASTERS - 1);
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            mgrant_q  <= mgrant_d;
            gid_q     <= gid_d;
            gvalid_q  <= gvalid_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
        end
    end

    assign abus_mgrant  = mgrant_q;
    assign abus_gid     = gid_q;
    assign abus_gvalid  = gvalid_q;
    assign abus_timeout = timeout_q;

endmodule

// File: tb/tb_abus_arbiter.sv
// Directed self-checking bench for abus_arbiter (NB_MASTERS=4, TIMEOUT=8)
// using a round-robin reference model feeding an expected-grant queue.
module tb_abus_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [2:0] gid;
    } exp_t;

    logic       abus_clk;
    logic       abus_rstb;
    logic [3:0] abus_mreq;
    logic       abus_mack;
    logic [3:0] abus_mgrant;
    logic [2:0] abus_gid;
    logic       abus_gvalid;
    logic       abus_timeout;

    int   n_checks;
    int   n_fail;
    int   model_last;
    exp_t exp_q[$];

    abus_arbiter #(
        .NB_MASTERS (4),
        .TIMEOUT    (8)
    ) dut (
        .abus_clk     (abus_clk),
        .abus_rstb    (abus_rstb),
        .abus_mreq    (abus_mreq),
        .abus_mack    (abus_mack),
        .abus_mgrant  (abus_mgrant),
        .abus_gid     (abus_gid),
        .abus_gvalid  (abus_gvalid),
        .abus_timeout (abus_timeout)
    );

    initial abus_clk = 1'b0;
    always #5 abus_clk = ~abus_clk;

    task automatic tick();
        @(negedge abus_clk);
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic ack);
        abus_mreq = req;
        abus_mack = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mgrant"}, 32'(abus_mgrant), 32'd0);
        checkOutput({tag, "_gid"}, 32'(abus_gid), 32'd0);
        checkOutput({tag, "_gvalid"}, 32'(abus_gvalid), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(abus_timeout), 32'd0);
    endtask

    // Reference round-robin: first requester after model_last, wrapping.
    task automatic pushExpected(input logic [3:0] req);
        int   c;
        exp_t e;
        for (int i = 1; i <= 4; i++) begin
            c = (model_last + i) % 4;
            if (req[c[1:0]]) break;
        end
        e.grant    = 4'(1 << c);
        e.gid      = 3'(c);
        model_last = c;
        exp_q.push_back(e);
    endtask

    task automatic expectGrant(output int waited);
        exp_t e;
        waited = 0;
        while (!abus_gvalid && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("grant_seen", 32'(abus_gvalid), 32'd1);
        if (exp_q.size() == 0) begin
            checkOutput("queue_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput("mgrant", 32'(abus_mgrant), 32'(e.grant));
            checkOutput("gid", 32'(abus_gid), 32'(e.gid));
        end
    endtask

    task automatic doReset();
        abus_rstb = 1'b0;
        model_last = 3;
        tick();
        abus_rstb = 1'b1;
        tick();
    endtask

    initial begin
        int waited;
        int hi;
        n_checks   = 0;
        n_fail     = 0;
        model_last = 3;
        abus_rstb  = 1'b0;
        applyStimulus(4'b0000, 1'b0);

        // Reset values while reset is held
        #1;
        checkIdleOutputs("reset");
        tick();
        abus_rstb = 1'b1;
        tick();

        // Single request from master 2, completed by a one-cycle ack
        applyStimulus(4'b0100, 1'b0);
        pushExpected(4'b0100);
        expectGrant(waited);
        checkOutput("req_to_grant_latency", 32'(waited), 32'd1);
        applyStimulus(4'b0100, 1'b1);
        tick();
        checkIdleOutputs("single_done");
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        // Fairness: all four request, expect 0,1,2,3,0 at 3-cycle spacing
        doReset();
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pushExpected(4'b1111);
            expectGrant(waited);
            if (i > 0) checkOutput("fair_spacing", 32'(1 + waited), 32'd3);
            applyStimulus(4'b1111, 1'b1);
            tick();
            checkOutput("fair_release", 32'(abus_gvalid), 32'd0);
            applyStimulus((i == 4) ? 4'b0000 : 4'b1111, 1'b0);
        end
        tick();
        tick();
        tick();
        checkOutput("fair_quiet", 32'(abus_gvalid), 32'd0);

        // Watchdog: master 1 never acks; master 3 arrives meanwhile
        applyStimulus(4'b0010, 1'b0);
        pushExpected(4'b0010);
        expectGrant(waited);
        applyStimulus(4'b1010, 1'b0);
        hi = 0;
        while (abus_gvalid && hi < 30) begin
            hi++;
            tick();
        end
        checkOutput("wd_grant_len", 32'(hi), 32'd8);
        checkOutput("wd_timeout_pulse", 32'(abus_timeout), 32'd1);
        tick();
        checkOutput("wd_timeout_one_cycle", 32'(abus_timeout), 32'd0);
        pushExpected(4'b1010);
        expectGrant(waited);
        applyStimulus(4'b1010, 1'b1);
        tick();
        applyStimulus(4'b0010, 1'b0);

        // Collision: ack lands on the same edge as watchdog expiry
        pushExpected(4'b0010);
        expectGrant(waited);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("col_still_granted", 32'(abus_gvalid), 32'd1);
        applyStimulus(4'b0010, 1'b1);
        tick();
        checkOutput("col_grant_dropped", 32'(abus_gvalid), 32'd0);
        checkOutput("col_no_timeout", 32'(abus_timeout), 32'd0);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("col_no_timeout_late", 32'(abus_timeout), 32'd0);
        tick();

        // Async reset while master 3 owns the bus
        applyStimulus(4'b1000, 1'b0);
        pushExpected(4'b1000);
        expectGrant(waited);
        #2;
        abus_rstb = 1'b0;
        #1;
        checkIdleOutputs("async_reset");
        model_last = 3;
        applyStimulus(4'b1111, 1'b0);
        tick();
        abus_rstb = 1'b1;
        pushExpected(4'b1111);
        expectGrant(waited);
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
